// File: rtl/fruit_pkg.sv
// Shared constants, lifecycle state type and a small bit-count helper for the fruit scheduler.
package fruit_pkg;

   localparam int NUM_FRUIT = 3;
   localparam int APPLE     = 0;
   localparam int ORANGE    = 1;
   localparam int PEACH     = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_FLY    = 2'd2
   } fruit_state_e;

   function automatic logic [1:0] count_ones(input logic [NUM_FRUIT-1:0] v);
      logic [1:0] n;
      n = '0;
      for (int k = 0; k < NUM_FRUIT; k++) begin
         n = n + {1'b0, v[k]};
      end
      return n;
   endfunction

endpackage

// File: rtl/fruit_lifecycle.sv
// One fruit: IDLE -> LAUNCH -> FLY -> IDLE, with a frame-tick life counter.
// hit/miss are single-cycle exit strobes consumed by the scorer in the top level.
module fruit_lifecycle
   import fruit_pkg::*;
#(
   parameter int LIFETIME = 120
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   input  logic game_en,
   input  logic launch,
   input  logic sliced,
   output logic active,
   output logic new_pulse,
   output logic idle,
   output logic hit,
   output logic miss
);

   localparam int LIFE_W = $clog2(LIFETIME + 1);

   fruit_state_e      state_reg, state_next;
   logic [LIFE_W-1:0] life_reg, life_next;
   logic              expire;

   assign expire = game_en && frame_tick && (life_reg == LIFE_W'(LIFETIME - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         life_reg  <= '0;
      end else begin
         state_reg <= state_next;
         life_reg  <= life_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      life_next  = life_reg;
      hit        = 1'b0;
      miss       = 1'b0;
      active     = (state_reg != ST_IDLE);
      new_pulse  = (state_reg == ST_LAUNCH);
      idle       = (state_reg == ST_IDLE);
      case (state_reg)
         ST_IDLE: begin
            if (launch) begin
               state_next = ST_LAUNCH;
               life_next  = '0;
            end
         end
         ST_LAUNCH: state_next = ST_FLY;
         ST_FLY: begin
            // A slice on the same cycle as expiry counts as a hit.
            if (game_en) begin
               if (sliced) begin
                  hit        = 1'b1;
                  state_next = ST_IDLE;
               end else if (expire) begin
                  miss       = 1'b1;
                  state_next = ST_IDLE;
               end else if (frame_tick) begin
                  life_next = life_reg + 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/fruit_scheduler.sv
// Spawn arbitration (round-robin), scoring and game-over for three fruit lifecycles.
// Define FRUIT_SCHED_LFSR_EN to jitter the spawn gap by a 16-bit LFSR's low nibble.
module fruit_scheduler
   import fruit_pkg::*;
#(
   parameter int SPAWN_GAP  = 30,
   parameter int LIFETIME   = 120,
   parameter int MAX_LIVE   = 2,
   parameter int MISS_LIMIT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       game_en,
   input  logic [2:0] sliced,
   output logic [2:0] active,
   output logic [2:0] new_pulse,
   output logic [7:0] score,
   output logic [3:0] misses,
   output logic       game_over
);

   localparam int GAP_W = $clog2(SPAWN_GAP + 16 + 1);

   logic [GAP_W-1:0]     spawn_reg, spawn_next, gap_val;
   logic [1:0]           rr_reg, rr_next, idx;
   logic [7:0]           score_reg, score_next;
   logic [3:0]           misses_reg, misses_next;
   logic                 game_over_reg, game_over_next;
   logic [NUM_FRUIT-1:0] launch, idle, hit, miss;
   logic [1:0]           live_cnt, hit_cnt, miss_cnt;
   logic [8:0]           score_sum;
   logic [4:0]           miss_sum;
   logic                 spawn_ok, grant_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FRUIT; gi++) begin : g_fruit
         fruit_lifecycle #(.LIFETIME(LIFETIME)) u_fruit (
            .clk       (clk),
            .rst_n     (rst_n),
            .frame_tick(frame_tick),
            .game_en   (game_en),
            .launch    (launch[gi]),
            .sliced    (sliced[gi]),
            .active    (active[gi]),
            .new_pulse (new_pulse[gi]),
            .idle      (idle[gi]),
            .hit       (hit[gi]),
            .miss      (miss[gi])
         );
      end
   endgenerate

`ifdef FRUIT_SCHED_LFSR_EN
   logic [15:0]      lfsr_reg;
   logic [GAP_W-1:0] gap_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_reg <= 16'hACE1;
         gap_reg  <= GAP_W'(SPAWN_GAP);
      end else begin
         if (frame_tick)
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
         if (grant_ok)
            gap_reg <= GAP_W'(SPAWN_GAP) + GAP_W'(lfsr_reg[3:0]);
      end
   end

   assign gap_val = gap_reg;
`else
   assign gap_val = GAP_W'(SPAWN_GAP);
`endif

   assign live_cnt = count_ones(~idle);
   assign hit_cnt  = count_ones(hit);
   assign miss_cnt = count_ones(miss);
   // Spawning stops as soon as the miss limit is reached, not a cycle later.
   assign spawn_ok = game_en && !game_over_reg && (misses_reg < 4'(MISS_LIMIT));

   always_comb begin
      launch   = '0;
      rr_next  = rr_reg;
      grant_ok = 1'b0;
      idx      = '0;
      if (spawn_ok && (spawn_reg == gap_val) && (live_cnt < 2'(MAX_LIVE))) begin
         for (int k = 0; k < NUM_FRUIT; k++) begin
            idx = 2'((int'(rr_reg) + k) % NUM_FRUIT);
            if (!grant_ok && idle[idx]) begin
               launch[idx] = 1'b1;
               grant_ok    = 1'b1;
               rr_next     = (idx == 2'(NUM_FRUIT - 1)) ? 2'(APPLE) : idx + 2'd1;
            end
         end
      end
   end

   always_comb begin
      spawn_next = spawn_reg;
      if (grant_ok)
         spawn_next = '0;
      else if (frame_tick && game_en && !game_over_reg && (spawn_reg < gap_val))
         spawn_next = spawn_reg + 1'b1;
      score_sum      = {1'b0, score_reg} + 9'(hit_cnt);
      miss_sum       = {1'b0, misses_reg} + 5'(miss_cnt);
      score_next     = score_sum[8] ? 8'hFF : score_sum[7:0];
      misses_next    = miss_sum[4] ? 4'hF : miss_sum[3:0];
      game_over_next = game_over_reg | (misses_reg >= 4'(MISS_LIMIT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spawn_reg     <= '0;
         rr_reg        <= 2'(APPLE);
         score_reg     <= '0;
         misses_reg    <= '0;
         game_over_reg <= 1'b0;
      end else begin
         spawn_reg     <= spawn_next;
         rr_reg        <= rr_next;
         score_reg     <= score_next;
         misses_reg    <= misses_next;
         game_over_reg <= game_over_next;
      end
   end

   assign score     = score_reg;
   assign misses    = misses_reg;
   assign game_over = game_over_reg;

endmodule

// File: tb/tb_fruit_scheduler.sv
// Directed scoreboard bench for fruit_scheduler: launches and score/miss/game_over changes are checked by a monitor.
module tb_fruit_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       frame_tick = 1'b0;
   logic       game_en = 1'b0;
   logic [2:0] sliced = 3'b000;
   logic [2:0] active;
   logic [2:0] new_pulse;
   logic [7:0] score;
   logic [3:0] misses;
   logic       game_over;

   int checks = 0;
   int errors = 0;

   // launch_q entries: {new_pulse, active}; status_q entries: {active, score, misses, game_over}
   logic [5:0]  launch_q[$];
   logic [15:0] status_q[$];
   logic [12:0] prev_status = '0;

   always #5 clk = ~clk;

   fruit_scheduler #(
      .SPAWN_GAP (30),
      .LIFETIME  (120),
      .MAX_LIVE  (2),
      .MISS_LIMIT(3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_tick(frame_tick),
      .game_en   (game_en),
      .sliced    (sliced),
      .active    (active),
      .new_pulse (new_pulse),
      .score     (score),
      .misses    (misses),
      .game_over (game_over)
   );

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end else begin
         $display("ok   %s %h", name, got);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [12:0] cur;
      cur = {score, misses, game_over};
      if (new_pulse != 3'b000) begin
         if (launch_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL launch_unexpected got new_pulse=%b active=%b want none", new_pulse, active);
         end else begin
            check("launch", 16'({new_pulse, active}), 16'(launch_q.pop_front()));
         end
      end
      if (cur != prev_status) begin
         if (status_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL status_unexpected got active=%b score=%0d misses=%0d game_over=%b want none",
                     active, score, misses, game_over);
         end else begin
            check("status", {active, cur}, status_q.pop_front());
         end
      end
      prev_status = cur;
   end

   task automatic tick_s(input logic [2:0] mask);
      @(posedge clk);
      #1 frame_tick = 1'b1;
      sliced = mask;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      sliced = 3'b000;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick_s(3'b000);
   endtask

   task automatic slice_only(input logic [2:0] mask);
      @(posedge clk);
      #1 sliced = mask;
      @(posedge clk);
      #1 sliced = 3'b000;
   endtask

   task automatic settle(input string name);
      repeat (4) @(posedge clk);
      #1;
      check({name, "_launch_pending"}, 16'(launch_q.size()), 16'd0);
      check({name, "_status_pending"}, 16'(status_q.size()), 16'd0);
   endtask

   task automatic exp_launch(input logic [2:0] np, input logic [2:0] act);
      launch_q.push_back({np, act});
   endtask

   task automatic exp_status(input logic [2:0] act, input logic [7:0] sc, input logic [3:0] ms, input logic go);
      status_q.push_back({act, sc, ms, go});
   endtask

   task automatic check_cleared(input string name);
      check({name, "_active"}, 16'(active), 16'd0);
      check({name, "_new_pulse"}, 16'(new_pulse), 16'd0);
      check({name, "_score"}, 16'(score), 16'd0);
      check({name, "_misses"}, 16'(misses), 16'd0);
      check({name, "_game_over"}, 16'(game_over), 16'd0);
   endtask

   task automatic mid_reset();
      exp_status(3'b000, 8'd0, 4'd0, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_cleared("async_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check_cleared("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      game_en = 1'b1;

      // Apple first, then orange one gap later.
      ticks(29); exp_launch(3'b001, 3'b001); ticks(1); settle("apple_spawn");
      ticks(29); exp_launch(3'b010, 3'b011); ticks(1); settle("orange_spawn");
      // Third gap elapses with two fruits live: peach must wait.
      ticks(30); settle("max_live_hold");
      // Slice apple: score 1, then the held spawn goes to peach.
      exp_status(3'b010, 8'd1, 4'd0, 1'b0);
      exp_launch(3'b100, 3'b110);
      slice_only(3'b001); settle("apple_slice");
      // Orange reaches its 120th tick on the same edge it is sliced.
      ticks(89);
      exp_status(3'b100, 8'd2, 4'd0, 1'b0);
      exp_launch(3'b001, 3'b101);
      tick_s(3'b010); settle("slice_vs_expire");
      // Peach expires: miss 1, orange takes the freed slot.
      ticks(29);
      exp_status(3'b001, 8'd2, 4'd1, 1'b0);
      exp_launch(3'b010, 3'b011);
      ticks(1); settle("peach_miss");
      // Apple expires: miss 2, peach relaunches.
      ticks(89);
      exp_status(3'b010, 8'd2, 4'd2, 1'b0);
      exp_launch(3'b100, 3'b110);
      ticks(1); settle("apple_miss");
      // Orange expires: miss 3, game_over one cycle later, no spawn.
      ticks(29);
      exp_status(3'b100, 8'd2, 4'd3, 1'b0);
      exp_status(3'b100, 8'd2, 4'd3, 1'b1);
      ticks(1); settle("game_over");
      // Peach still finishes its flight; nothing new spawns.
      ticks(89);
      exp_status(3'b000, 8'd2, 4'd4, 1'b1);
      ticks(1); settle("post_over_miss");
      ticks(40); settle("no_spawn_after_over");

      mid_reset();
      settle("reset_after_over");

      ticks(29); exp_launch(3'b001, 3'b001); ticks(1); settle("apple_respawn");
      // game_en low freezes the spawn counter across 40 ticks.
      ticks(20);
      game_en = 1'b0;
      ticks(40);
      game_en = 1'b1;
      ticks(9); exp_launch(3'b010, 3'b011); ticks(1); settle("freeze");
      exp_status(3'b010, 8'd1, 4'd0, 1'b0);
      slice_only(3'b001); settle("apple_slice2");
      // Reset with orange in flight; pointer returns to apple.
      ticks(5);
      mid_reset();
      settle("reset_mid_flight");
      ticks(29); exp_launch(3'b001, 3'b001); ticks(1); settle("apple_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fruit_scheduler.md
FRUIT_SCHEDULER -- requirements
Module: fruit_scheduler

Interface
REQ-001 Parameter SPAWN_GAP, default 30: frame ticks between spawn attempts.
REQ-002 Parameter LIFETIME, default 120: frame ticks a fruit stays in flight before it counts as missed.
REQ-003 Parameter MAX_LIVE, default 2: maximum fruits in flight at once (1..3).
REQ-004 Parameter MISS_LIMIT, default 3: miss count that ends the game.
REQ-005 Clock and reset SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: system clock.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-009 Port game_en, input, 1: enables spawning and timing.
REQ-010 Port sliced, input, 3: per-fruit sliced level; bit0 apple, bit1 orange, bit2 peach.
REQ-011 Port active, output, 3: fruit on screen, same bit order.
REQ-012 Port new_pulse, output, 3: one-cycle launch strobe per fruit.
REQ-013 Port score, output, 8: fruits sliced, saturating.
REQ-014 Port misses, output, 4: fruits expired unsliced.
REQ-015 Port game_over, output, 1: level, set when misses reaches MISS_LIMIT.

Function
REQ-016 Each fruit SHALL run FSM IDLE -> LAUNCH -> FLY -> IDLE.
- LAUNCH lasts exactly 1 cycle.
- new_pulse[i] is high only in LAUNCH.
- active[i] is high in LAUNCH and FLY.
REQ-017 The spawn counter SHALL increment on frame_tick while game_en=1 and game_over=0, saturating at the gap value.
REQ-018 At the gap value, if live count < MAX_LIVE and at least one fruit is IDLE, one fruit SHALL be granted LAUNCH on the next clock and the counter SHALL clear.
- Grant is round-robin, starting after the last granted index; the first grant after reset is apple.
- Otherwise the counter holds until a grant is possible.
REQ-019 In FLY, a per-fruit life counter SHALL count frame_tick.
- sliced[i]=1 -> IDLE, score +1.
- Life counter reaching LIFETIME with sliced[i]=0 -> IDLE, misses +1.
REQ-020 sliced[i] SHALL be ignored outside FLY, so a stale sliced level during LAUNCH has no effect.
REQ-021 If a slice and an expiry occur in the same cycle, the slice SHALL win.
REQ-022 Multiple fruits exiting in one cycle SHALL add their full count to score or misses in that cycle.
- score saturates at 255.
- misses saturates at 15.
REQ-023 game_over SHALL assert in the cycle after misses reaches MISS_LIMIT.
- Spawning stops.
- Fruits in flight finish normally.
- game_over clears only on reset.
REQ-024 game_en=0 SHALL freeze the spawn and life counters; FSM states and outputs hold.

Reset
REQ-025 On rst_n=0, all FSMs SHALL go to IDLE and the following SHALL clear immediately: active, new_pulse, score, misses, game_over, all counters, and the round-robin pointer (next grant = apple).
REQ-026 Reset mid-flight SHALL drop active with no score or miss update.

Configuration
REQ-027 Macro FRUIT_SCHED_LFSR_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, advances every frame_tick) SHALL add its low 4 bits to SPAWN_GAP, sampled each time the spawn counter clears.
- Undefined: the gap SHALL be exactly SPAWN_GAP and no LFSR is built.

Structure
REQ-028 Package fruit_pkg SHALL hold NUM_FRUIT=3, the fruit index constants (APPLE=0, ORANGE=1, PEACH=2) and the lifecycle state enum.
REQ-029 Sub-module fruit_lifecycle SHALL implement one fruit FSM plus its life counter and be instantiated 3 times; spawn arbitration and scoring stay in the top level.

Verification
REQ-030 Directed scenarios:
- Reset, game_en=1, 30 frame_ticks -> new_pulse=3'b001 for 1 cycle, then active=3'b001.
- Two more spawn gaps -> orange launches, then the third spawn waits because MAX_LIVE=2; peach launches only after a fruit exits.
- sliced[0]=1 during FLY -> active[0]=0 next cycle, score=1.
- No slice for 120 ticks, three times -> misses=3, game_over=1, no new_pulse thereafter.
- Slice and expiry in the same cycle on orange -> score +1, misses unchanged.
- Reset asserted mid-flight -> all outputs 0 asynchronously; next spawn is apple.
